// File: rtl/neureka_binconv_col_ctrl.sv
// Column controller for the binary-convolution engine: sequences the weight
// bit-planes of each input-channel tile, tracks beats in flight towards the
// column and drains them before reporting completion.
module neureka_binconv_col_ctrl #(
    parameter int QW_MAX    = 8,
    parameter int MAX_OUTST = 4,
    parameter int ITER_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [3:0]        cfg_qw_i,
    input  logic [ITER_W-1:0] cfg_n_iter_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic              cfg_woff_en_i,
    input  logic [3:0]        cfg_woff_scale_i,
    input  logic [3:0]        cfg_scale_shift_i,
    input  logic              fire_i,
    input  logic              pres_valid_i,
    input  logic              pres_ready_i,
    output logic              issue_en_o,
    output logic              clear_o,
    output logic              enable_o,
    output logic              weight_offset_o,
    output logic              dw_weight_offset_o,
    output logic [3:0]        block_cnt_o,
    output logic [3:0]        scale_shift_o,
    output logic [3:0]        woff_scale_o,
    output logic [1:0]        filter_mode_o,
    output logic              invalidate_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        OFFSET = 3'd2,
        BITS   = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        qw_q;
    logic [ITER_W-1:0] n_iter_q;
    logic [1:0]        mode_q;
    logic              woff_en_q;
    logic [3:0]        woff_scale_q;
    logic [3:0]        scale_shift_q;

    logic [3:0]        bit_q;
    logic [ITER_W-1:0] iter_q;
    logic [OW-1:0]     outst_q;

    logic counted;
    logic ret;
    logic last_bit;
    logic last_iter;
    logic accept;
    logic kill;

    // Out-of-range plane counts are pulled into the supported 1..QW_MAX window.
    function automatic logic [3:0] clamp_qw(input logic [3:0] qw);
        if (qw == 4'd0)
            return 4'd1;
        else if (int'(qw) > QW_MAX)
            return 4'(QW_MAX);
        else
            return qw;
    endfunction

    // A zero tile count still runs one tile.
    function automatic logic [ITER_W-1:0] clamp_iter(input logic [ITER_W-1:0] n);
        if (n == '0)
            return ITER_W'(1);
        else
            return n;
    endfunction

    assign accept    = (state == IDLE) && start_i;
    assign kill      = (state != IDLE) && abort_i;
    assign issue_en_o = ((state == OFFSET) || (state == BITS)) &&
                        (outst_q < OW'(MAX_OUTST));
    assign counted   = fire_i & issue_en_o;
    assign ret       = pres_valid_i & pres_ready_i;
    assign last_bit  = (bit_q == (qw_q - 4'd1));
    assign last_iter = (iter_q == (n_iter_q - ITER_W'(1)));

    assign enable_o           = (state == OFFSET) || (state == BITS) || (state == DRAIN);
    assign dw_weight_offset_o = enable_o;
    assign busy_o             = (state != IDLE);
    assign scale_shift_o      = scale_shift_q;
    assign woff_scale_o       = woff_scale_q;
    assign filter_mode_o      = mode_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and per-state strobes; abort overrides everything.
    always_comb begin
        state_nxt       = state;
        clear_o         = 1'b0;
        weight_offset_o = 1'b0;
        block_cnt_o     = 4'd0;
        invalidate_o    = 1'b0;
        done_o          = 1'b0;
        case (state)
            IDLE: begin
                if (start_i)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                clear_o   = 1'b1;
                state_nxt = woff_en_q ? OFFSET : BITS;
            end
            OFFSET: begin
                weight_offset_o = 1'b1;
                if (counted)
                    state_nxt = BITS;
            end
            BITS: begin
                block_cnt_o = bit_q;
                if (counted && last_bit && last_iter)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                invalidate_o = (mode_q == 2'd2);
                if (outst_q == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (kill) begin
            state_nxt = IDLE;
            clear_o   = 1'b1;
            done_o    = 1'b0;
        end
    end

    // Job configuration is captured only when a start is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            qw_q          <= 4'd0;
            n_iter_q      <= '0;
            mode_q        <= 2'd0;
            woff_en_q     <= 1'b0;
            woff_scale_q  <= 4'd0;
            scale_shift_q <= 4'd0;
        end else if (accept) begin
            qw_q          <= clamp_qw(cfg_qw_i);
            n_iter_q      <= clamp_iter(cfg_n_iter_i);
            mode_q        <= cfg_mode_i;
            woff_en_q     <= cfg_woff_en_i;
            woff_scale_q  <= cfg_woff_scale_i;
            scale_shift_q <= cfg_scale_shift_i;
        end
    end

    // Bit-plane and tile counters; the offset beat leaves both at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || kill || accept) begin
            bit_q  <= 4'd0;
            iter_q <= '0;
        end else if (counted && (state == BITS)) begin
            if (last_bit) begin
                bit_q  <= 4'd0;
                iter_q <= last_iter ? '0 : iter_q + ITER_W'(1);
            end else begin
                bit_q <= bit_q + 4'd1;
            end
        end
    end

    // Beats in flight: a simultaneous issue and return cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i || kill || accept)
            outst_q <= '0;
        else if (counted && !ret)
            outst_q <= outst_q + OW'(1);
        else if (ret && !counted && (outst_q != '0))
            outst_q <= outst_q - OW'(1);
    end

endmodule

// File: tb/tb_neureka_binconv_col_ctrl.sv
// Randomised bench for the column controller, checked against a beat-count
// model of the job (clear cycle, issue window, drain, done).
module tb_neureka_binconv_col_ctrl;

    localparam int QW_MAX    = 8;
    localparam int MAX_OUTST = 4;
    localparam int ITER_W    = 16;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [3:0]        cfg_qw;
    logic [ITER_W-1:0] cfg_n_iter;
    logic [1:0]        cfg_mode;
    logic              cfg_woff_en;
    logic [3:0]        cfg_woff_scale, cfg_scale_shift;
    logic              fire, pres_valid, pres_ready;
    logic              issue_en, clear, enable, weight_offset, dw_weight_offset;
    logic [3:0]        block_cnt, scale_shift, woff_scale;
    logic [1:0]        filter_mode;
    logic              invalidate, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;
    int tr_bc[$];
    int tr_wo[$];
    int tr_issue[$];
    int tr_hs[$];
    int tr_clear[$];
    int n_done, done_cyc, n_both;

    always #5 clk = ~clk;

    neureka_binconv_col_ctrl #(
        .QW_MAX(QW_MAX), .MAX_OUTST(MAX_OUTST), .ITER_W(ITER_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .cfg_qw_i(cfg_qw), .cfg_n_iter_i(cfg_n_iter), .cfg_mode_i(cfg_mode),
        .cfg_woff_en_i(cfg_woff_en), .cfg_woff_scale_i(cfg_woff_scale),
        .cfg_scale_shift_i(cfg_scale_shift), .fire_i(fire),
        .pres_valid_i(pres_valid), .pres_ready_i(pres_ready),
        .issue_en_o(issue_en), .clear_o(clear), .enable_o(enable),
        .weight_offset_o(weight_offset), .dw_weight_offset_o(dw_weight_offset),
        .block_cnt_o(block_cnt), .scale_shift_o(scale_shift),
        .woff_scale_o(woff_scale), .filter_mode_o(filter_mode),
        .invalidate_o(invalidate), .busy_o(busy), .done_o(done)
    );

    task automatic drive_idle_inputs();
        start = 1'b0; abort = 1'b0; fire = 1'b0;
        pres_valid = 1'b0; pres_ready = 1'b0;
    endtask

    // ret_mode 0: random handshakes (ret_param = ready percent)
    // ret_mode 1: each result returned ret_param cycles after its beat
    // ret_mode 2: valid held high, ready held low until cycle ret_param
    task automatic run_job(input int qw_c, input int ni_c, input bit woff, input int mode,
                           input int fire_pct, input int ret_mode, input int ret_param,
                           input int abort_beat, input bit abort_with_start,
                           input bit stray_start);
        int qw_e, ni_e, total, beats, outst, phase, o_before, exp_bc;
        int due[$];
        logic [3:0]  ss, ws;
        logic [21:0] got, exp;
        bit abort_now, counted, hs, exp_issue, exp_en;
        qw_e  = (qw_c == 0) ? 1 : ((qw_c > QW_MAX) ? QW_MAX : qw_c);
        ni_e  = (ni_c == 0) ? 1 : ni_c;
        total = (woff ? 1 : 0) + qw_e * ni_e;
        ss = 4'($urandom);
        ws = 4'($urandom);
        tr_bc.delete(); tr_wo.delete(); tr_issue.delete(); tr_hs.delete(); tr_clear.delete();
        n_done = 0; done_cyc = -1; n_both = 0;
        @(negedge clk);
        cfg_qw = 4'(qw_c); cfg_n_iter = ITER_W'(ni_c); cfg_mode = 2'(mode);
        cfg_woff_en = woff; cfg_woff_scale = ws; cfg_scale_shift = ss;
        start = 1'b1; abort = abort_with_start; fire = 1'b0;
        pres_valid = 1'b0; pres_ready = 1'b0;
        @(posedge clk);
        beats = 0; outst = 0; phase = 0;
        for (int cyc = 0; cyc < 3000 && phase != 4; cyc++) begin
            @(negedge clk);
            start = stray_start && ($urandom_range(0, 3) == 0);
            if (stray_start) begin
                cfg_qw = 4'($urandom); cfg_mode = 2'($urandom); cfg_woff_en = 1'($urandom);
                cfg_n_iter = ITER_W'($urandom); cfg_woff_scale = 4'($urandom);
                cfg_scale_shift = 4'($urandom);
            end
            fire = int'($urandom_range(0, 99)) < fire_pct;
            abort_now = (abort_beat >= 0) && (phase == 1) && (beats == abort_beat);
            abort = abort_now;
            case (ret_mode)
                1: begin
                    pres_valid = (due.size() > 0) && (due[0] == cyc);
                    pres_ready = pres_valid;
                end
                2: begin
                    pres_valid = 1'b1;
                    pres_ready = (cyc >= ret_param);
                end
                default: begin
                    pres_valid = int'($urandom_range(0, 99)) < 60;
                    pres_ready = int'($urandom_range(0, 99)) < ret_param;
                end
            endcase
            #1;
            exp_issue = (phase == 1) && (outst < MAX_OUTST);
            exp_en    = (phase == 1) || (phase == 2);
            exp_bc    = (phase == 1) ? (woff ? ((beats == 0) ? 0 : (beats - 1) % qw_e)
                                             : beats % qw_e) : 0;
            exp = {exp_issue, exp_en, 1'b1, (phase == 0) || abort_now,
                   (phase == 3) && !abort_now, 4'(exp_bc),
                   (phase == 1) && woff && (beats == 0), exp_en,
                   (phase == 2) && (mode == 2), 2'(mode), ss, ws};
            got = {issue_en, enable, busy, clear, done, block_cnt, weight_offset,
                   dw_weight_offset, invalidate, filter_mode, scale_shift, woff_scale};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL job_cycle cyc=%0d phase=%0d got=%h exp=%h", cyc, phase, got, exp);
            end
            counted = fire && exp_issue;
            hs      = pres_valid && pres_ready;
            tr_issue.push_back(int'(issue_en));
            tr_hs.push_back(int'(hs));
            tr_clear.push_back(int'(clear));
            if (done) begin n_done++; done_cyc = cyc; end
            if (counted && hs) n_both++;
            if (counted && !abort_now) begin
                tr_bc.push_back(int'(block_cnt));
                tr_wo.push_back(int'(weight_offset));
                due.push_back(cyc + ret_param);
            end
            if (hs && ret_mode == 1) void'(due.pop_front());
            o_before = outst;
            if (counted && !hs) outst++;
            else if (hs && !counted && outst > 0) outst--;
            if (abort_now) phase = 4;
            else begin
                case (phase)
                    0: phase = 1;
                    1: if (counted) begin
                        beats++;
                        if (beats == total) phase = 2;
                    end
                    2: if (o_before == 0) phase = 3;
                    3: phase = 4;
                    default: ;
                endcase
            end
        end
        if (phase != 4) begin
            n_cmp++; n_fail++;
            $display("FAIL job_timeout got=phase%0d exp=idle", phase);
            rst = 1'b1; drive_idle_inputs();
            @(posedge clk); @(negedge clk); rst = 1'b0;
        end else begin
            @(negedge clk);
            drive_idle_inputs();
            #1;
            exp = {5'b0, 4'd0, 3'b0, 2'(mode), ss, ws};
            got = {issue_en, enable, busy, clear, done, block_cnt, weight_offset,
                   dw_weight_offset, invalidate, filter_mode, scale_shift, woff_scale};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL idle_after_job got=%h exp=%h", got, exp);
            end
        end
    endtask

    task automatic test_reset();
        logic [29:0] all;
        int dn;
        rst = 1'b1; drive_idle_inputs();
        cfg_qw = 4'd0; cfg_n_iter = '0; cfg_mode = 2'd0; cfg_woff_en = 1'b0;
        cfg_woff_scale = 4'd0; cfg_scale_shift = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        all = {issue_en, clear, enable, weight_offset, dw_weight_offset, block_cnt,
               scale_shift, woff_scale, filter_mode, invalidate, busy, done, 11'd0};
        n_cmp++;
        if (all !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", all); end
        @(negedge clk);
        rst = 1'b0;
        cfg_qw = 4'd3; cfg_n_iter = ITER_W'(2); cfg_mode = 2'd2;
        cfg_woff_scale = 4'd9; cfg_scale_shift = 4'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; fire = 1'b1;
        #1;
        n_cmp++;
        if ({busy, clear} !== 2'b11) begin
            n_fail++; $display("FAIL reset_job_started got=%b exp=11", {busy, clear});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        all = {issue_en, clear, enable, weight_offset, dw_weight_offset, block_cnt,
               scale_shift, woff_scale, filter_mode, invalidate, busy, done, 11'd0};
        n_cmp++;
        if (all !== '0) begin n_fail++; $display("FAIL reset_midjob got=%h exp=0", all); end
        @(negedge clk);
        rst = 1'b0; pres_valid = 1'b1; pres_ready = 1'b1;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        n_cmp++;
        if (dn !== 0) begin n_fail++; $display("FAIL reset_no_done got=%0d exp=0", dn); end
        drive_idle_inputs();
    endtask

    task automatic test_basic();
        int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int last_hs;
        run_job(4, 2, 0, 0, 100, 1, 2, -1, 0, 0);
        n_cmp++;
        if (tr_bc.size() != 8) begin
            n_fail++; $display("FAIL basic_beats got=%0d exp=8", tr_bc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (tr_bc[i] != exp_seq[i]) begin
                    n_fail++; $display("FAIL basic_bc[%0d] got=%0d exp=%0d", i, tr_bc[i], exp_seq[i]);
                end
            end
        end
        last_hs = -1;
        for (int i = 0; i < tr_hs.size(); i++) if (tr_hs[i] != 0) last_hs = i;
        n_cmp++;
        if (n_done != 1 || done_cyc <= last_hs) begin
            n_fail++;
            $display("FAIL basic_done got=%0d@%0d exp=1 after %0d", n_done, done_cyc, last_hs);
        end
    endtask

    task automatic test_woff();
        int exp_wo[3] = '{1, 0, 0};
        int exp_bc[3] = '{0, 0, 1};
        run_job(2, 1, 1, 1, 100, 1, 1, -1, 0, 0);
        n_cmp++;
        if (tr_bc.size() != 3) begin
            n_fail++; $display("FAIL woff_beats got=%0d exp=3", tr_bc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (tr_wo[i] != exp_wo[i] || tr_bc[i] != exp_bc[i]) begin
                    n_fail++;
                    $display("FAIL woff_beat[%0d] got=%0d/%0d exp=%0d/%0d",
                             i, tr_wo[i], tr_bc[i], exp_wo[i], exp_bc[i]);
                end
            end
        end
        n_cmp++;
        if (n_done != 1) begin n_fail++; $display("FAIL woff_done got=%0d exp=1", n_done); end
    endtask

    task automatic test_outstanding();
        int ones, r;
        run_job(8, 2, 0, 0, 100, 2, 10, -1, 0, 0);
        ones = 0;
        for (int i = 1; i <= 4; i++) ones += tr_issue[i];
        n_cmp++;
        if (ones != 4 || tr_issue[5] != 0) begin
            n_fail++; $display("FAIL outst_fall got=%0d,%0d exp=4,0", ones, tr_issue[5]);
        end
        r = -1;
        for (int i = 0; i < tr_hs.size(); i++) if (r < 0 && tr_hs[i] != 0) r = i;
        n_cmp++;
        if (r < 0 || tr_issue[r] != 0 || tr_issue[r + 1] != 1) begin
            n_fail++; $display("FAIL outst_rise got=hs@%0d exp=issue 0 then 1", r);
        end
    endtask

    task automatic test_simultaneous();
        int zeros;
        run_job(8, 2, 0, 0, 100, 1, 3, -1, 0, 0);
        zeros = 0;
        for (int i = 1; i <= 16; i++) if (tr_issue[i] == 0) zeros++;
        n_cmp++;
        if (zeros != 0 || n_both < 10) begin
            n_fail++; $display("FAIL simul_outst got=drops%0d both%0d exp=0,>=10", zeros, n_both);
        end
    endtask

    task automatic test_abort();
        int clr;
        run_job(3, 3, 0, 2, 100, 1, 2, 3, 0, 0);
        clr = 0;
        foreach (tr_clear[i]) clr += tr_clear[i];
        n_cmp++;
        if (clr != 2 || n_done != 0 || tr_bc.size() != 3) begin
            n_fail++;
            $display("FAIL abort got=clr%0d done%0d beats%0d exp=2,0,3", clr, n_done, tr_bc.size());
        end
        run_job(2, 2, 1, 2, 70, 0, 50, -1, 1, 1);
        n_cmp++;
        if (n_done != 1) begin n_fail++; $display("FAIL abort_with_start got=%0d exp=1", n_done); end
    endtask

    task automatic test_clamp();
        run_job(0, 0, 0, 1, 100, 1, 2, -1, 0, 0);
        n_cmp++;
        if (tr_bc.size() != 1 || tr_bc[0] != 0 || n_done != 1) begin
            n_fail++; $display("FAIL clamp_zero got=beats%0d done%0d exp=1,1", tr_bc.size(), n_done);
        end
        run_job(15, 1, 0, 0, 100, 1, 2, -1, 0, 0);
        n_cmp++;
        if (tr_bc.size() != 8 || tr_bc[7] != 7) begin
            n_fail++; $display("FAIL clamp_max got=beats%0d exp=8 ending at 7", tr_bc.size());
        end
    endtask

    task automatic test_random();
        int qw, ni, md, fp, ab, qe, tot, exp_done;
        bit wo;
        for (int j = 0; j < 8; j++) begin
            qw = $urandom_range(0, 15);
            ni = $urandom_range(0, 3);
            wo = 1'($urandom);
            md = $urandom_range(0, 2);
            fp = $urandom_range(30, 100);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            qe = (qw == 0) ? 1 : ((qw > QW_MAX) ? QW_MAX : qw);
            tot = (wo ? 1 : 0) + qe * ((ni == 0) ? 1 : ni);
            exp_done = (ab >= 0 && ab < tot) ? 0 : 1;
            if (j % 2 == 0) run_job(qw, ni, wo, md, fp, 0, 50, ab, 0, 1);
            else            run_job(qw, ni, wo, md, fp, 1, $urandom_range(1, 6), ab, 0, 1);
            n_cmp++;
            if (n_done != exp_done) begin
                n_fail++; $display("FAIL random_done job=%0d got=%0d exp=%0d", j, n_done, exp_done);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle_inputs();
        cfg_qw = 4'd0; cfg_n_iter = '0; cfg_mode = 2'd0; cfg_woff_en = 1'b0;
        cfg_woff_scale = 4'd0; cfg_scale_shift = 4'd0;
        test_reset();
        test_basic();
        test_woff();
        test_outstanding();
        test_simultaneous();
        test_abort();
        test_clamp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/neureka_binconv_col_ctrl.md
NEUREKA_BINCONV_COL_CTRL -- requirements
Module: neureka_binconv_col_ctrl

Interface
REQ-001 SHALL have parameter QW_MAX, default 8: maximum weight bit-planes per input tile.
REQ-002 SHALL have parameter MAX_OUTST, default 4: maximum issued beats without a result.
REQ-003 SHALL have parameter ITER_W, default 16: width of the tile-iteration counter.
REQ-004 SHALL have these ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start pulse; the block latches all cfg_* on acceptance.
- abort_i  in  1  abort the current job.
- cfg_qw_i  in  4  weight bit-planes, 1..QW_MAX.
- cfg_n_iter_i  in  ITER_W  number of input-channel tiles.
- cfg_mode_i  in  2  filter mode: 0=3x3, 1=1x1, 2=3x3 DW.
- cfg_woff_en_i  in  1  run a weight-offset pass.
- cfg_woff_scale_i  in  4  shift applied in the weight-offset pass.
- cfg_scale_shift_i  in  4  shift applied in 1x1 mode.
- fire_i  in  1  column accepted an activation beat (activation valid&ready).
- pres_valid_i  in  1  column result valid.
- pres_ready_i  in  1  column result ready.
- issue_en_o  out  1  column may accept a beat.
- clear_o  out  1  column clear.
- enable_o  out  1  column enable.
- weight_offset_o  out  1  weight-offset pass active.
- dw_weight_offset_o  out  1  multiplexer gate.
- block_cnt_o  out  4  current bit-plane index.
- scale_shift_o  out  4  latched cfg_scale_shift_i.
- woff_scale_o  out  4  latched cfg_woff_scale_i.
- filter_mode_o  out  2  latched cfg_mode_i.
- invalidate_o  out  1  beat invalidation.
- busy_o  out  1  job in progress.
- done_o  out  1  job complete.

Function
REQ-005 FSM states SHALL be IDLE, CLEAR, OFFSET, BITS, DRAIN and DONE; the state register advances only on rising clk_i.
REQ-006 IDLE: start_i=1 SHALL latch the configuration and go to CLEAR next cycle; start_i outside IDLE SHALL be ignored.
REQ-007 On latch, cfg_qw_i=0 or cfg_qw_i>QW_MAX SHALL be clamped to 1 or QW_MAX respectively; cfg_n_iter_i=0 SHALL be treated as 1.
REQ-008 CLEAR SHALL last exactly 1 cycle with clear_o=1, then go to OFFSET if woff_en was latched as 1, else to BITS.
REQ-009 OFFSET: weight_offset_o=1, block_cnt_o=0; the first counted fire_i SHALL go to BITS with bit=0 and iter=0.
REQ-010 BITS: block_cnt_o=bit; each counted fire_i SHALL increment bit; when bit=qw-1 it wraps to 0 and iter increments.
REQ-011 A counted fire_i at bit=qw-1 and iter=n_iter-1 SHALL go to DRAIN.
REQ-012 A counted fire_i is fire_i&issue_en_o; fire_i while issue_en_o=0 SHALL be ignored by all counters.
REQ-013 issue_en_o SHALL be 1 iff the state is OFFSET or BITS and outst<MAX_OUTST.
REQ-014 Counter outst SHALL:
- increment on a counted fire_i;
- decrement on pres_valid_i&pres_ready_i;
- be unchanged when both happen in the same cycle;
- never underflow (a decrement at 0 is ignored).
REQ-015 DRAIN SHALL go to DONE in the cycle after outst reaches 0, and SHALL go directly to DONE if outst is already 0 on entry.
REQ-016 DONE SHALL last 1 cycle with done_o=1, then return to IDLE.
REQ-017 enable_o SHALL be 1 in OFFSET, BITS and DRAIN; busy_o SHALL be 1 in every state except IDLE.
REQ-018 dw_weight_offset_o SHALL equal enable_o.
REQ-019 invalidate_o SHALL be 1 only in DRAIN when the latched mode is 2 (3x3 DW).
REQ-020 abort_i SHALL take priority over every other event in any non-IDLE state:
- clear_o=1 that cycle;
- next state IDLE with all counters zeroed;
- done_o not asserted.
REQ-021 abort_i in IDLE SHALL have no effect; abort_i and start_i together in IDLE SHALL start the job.
REQ-022 Latched configuration outputs SHALL hold their values until the next accepted start_i.

Reset
REQ-023 With rst_i=1 at a clock edge the block SHALL enter IDLE, clear all counters and latched configuration to 0, and drive every output to 0.
REQ-024 Reset asserted mid-job SHALL discard the job without asserting done_o.

Verification
REQ-025 Test qw=4, n_iter=2, woff_en=0, fire_i held 1, results returned 2 cycles after each beat. Required:
- block_cnt_o sequence 0,1,2,3,0,1,2,3;
- 8 counted beats;
- done_o exactly once after the 8th result.
REQ-026 Test woff_en=1, qw=2, n_iter=1. Required: one beat with weight_offset_o=1, then block_cnt_o 0,1, then DONE.
REQ-027 Test MAX_OUTST=4 with pres_ready_i=0. Required: issue_en_o falls after the 4th beat and rises 1 cycle after the first returned result.
REQ-028 Test simultaneous counted fire and result handshake. Required: outst unchanged.
REQ-029 Test abort_i in BITS at iter=1. Required: clear_o=1 for 1 cycle, IDLE next cycle, done_o never asserted.
REQ-030 Test cfg_qw_i=0 and cfg_n_iter_i=0. Required: exactly 1 beat at block_cnt_o=0, then done_o.
